// File: rtl/input_debouncer_pkg.sv
// Shared state encodings and board-level defaults for the input debouncer.
// Gray-ordered codes: each legal transition flips a single state bit.
package input_debouncer_pkg;

  typedef enum logic [1:0] {
    ST_LOW    = 2'b00,
    ST_WAIT_H = 2'b01,
    ST_HIGH   = 2'b11,
    ST_WAIT_L = 2'b10
  } state_e;

  // 10 ms hold time at a 100 MHz board clock.
  localparam int BOARD_STABLE_CYCLES = 1_000_000;

endpackage

// File: rtl/input_debouncer_synchronizer.sv
// Flop chain that brings an asynchronous level into the clk domain; reusable for any board input.
// Latency SYNC_STAGES edges; no backpressure.
module input_debouncer_synchronizer #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/input_debouncer.sv
// Debounces a raw button/switch: synchronizer, then a counter-qualified 4-state FSM.
// z follows x after SYNC_STAGES+STABLE_CYCLES edges of steady input; no backpressure.
module input_debouncer
  import input_debouncer_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic x,
  output logic z,
  output logic settling
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             s;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  input_debouncer_synchronizer #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (x),
    .q  (s)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_LOW;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // cnt counts samples already seen at the candidate level, so it tops out at STABLE_CYCLES-1.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_LOW: begin
        if (s) begin
          if (STABLE_CYCLES == 1) begin
            state_d = ST_HIGH;
            cnt_d   = '0;
          end else begin
            state_d = ST_WAIT_H;
            cnt_d   = CNT_ONE;
          end
        end
      end
      ST_WAIT_H: begin
        if (!s) begin
          state_d = ST_LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = ST_HIGH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_HIGH: begin
        if (!s) begin
          if (STABLE_CYCLES == 1) begin
            state_d = ST_LOW;
            cnt_d   = '0;
          end else begin
            state_d = ST_WAIT_L;
            cnt_d   = CNT_ONE;
          end
        end
      end
      ST_WAIT_L: begin
        if (s) begin
          state_d = ST_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = ST_LOW;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_LOW;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    z        = (state_q == ST_HIGH)   || (state_q == ST_WAIT_L);
    settling = (state_q == ST_WAIT_H) || (state_q == ST_WAIT_L);
  end

endmodule

// File: tb/tb_input_debouncer.sv
// Directed bench for input_debouncer with SYNC_STAGES=2, STABLE_CYCLES=4 (6-edge latency).
// x changes 1 ns after each rising edge; outputs are read 1 ns after the edge.
module tb_input_debouncer;

  logic clk;
  logic rst;
  logic x;
  logic z;
  logic settling;

  int errors;
  int checks;

  input_debouncer #(
    .SYNC_STAGES  (2),
    .STABLE_CYCLES(4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .x       (x),
    .z       (z),
    .settling(settling)
  );

  initial clk = 1'b0;
  always #25 clk = ~clk;

  task automatic step(input logic xv);
    x = xv;
    @(posedge clk);
    #1;
  endtask

  task automatic settle(input logic xv);
    for (int i = 0; i < 10; i++) step(xv);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    x   = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (z !== 1'b0) begin
        errors++;
        $display("FAIL reset_z cycle %0d: got %b expected 0", i, z);
      end
      checks++;
      if (settling !== 1'b0) begin
        errors++;
        $display("FAIL reset_settling cycle %0d: got %b expected 0", i, settling);
      end
    end
    rst = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      step(1'b1);
      checks++;
      if (z !== (i == 6)) begin
        errors++;
        $display("FAIL post_reset_z edge %0d: got %b expected %b", i, z, (i == 6));
      end
    end
  endtask

  task automatic test_fall();
    logic [2:0] xs;
    logic       saw_settle;
    xs = 3'b000;
    saw_settle = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      step((i <= 3) ? xs[0] : 1'b1);
      if (settling === 1'b1) saw_settle = 1'b1;
      checks++;
      if (z !== 1'b1) begin
        errors++;
        $display("FAIL fall_short_z step %0d: got %b expected 1", i, z);
      end
    end
    checks++;
    if (saw_settle !== 1'b1) begin
      errors++;
      $display("FAIL fall_short_settling: got %b expected 1", saw_settle);
    end
    for (int i = 1; i <= 6; i++) begin
      step(1'b0);
      checks++;
      if (z !== (i < 6)) begin
        errors++;
        $display("FAIL fall_z edge %0d: got %b expected %b", i, z, (i < 6));
      end
    end
  endtask

  task automatic test_clean_rise();
    logic [5:0] exp_settle;
    logic [5:0] exp_z;
    exp_settle = 6'b011100;  // bit i-1 = after edge i
    exp_z      = 6'b100000;
    settle(1'b0);
    for (int i = 1; i <= 6; i++) begin
      step(1'b1);
      checks++;
      if (settling !== exp_settle[i-1]) begin
        errors++;
        $display("FAIL rise_settling edge %0d: got %b expected %b", i, settling, exp_settle[i-1]);
      end
      checks++;
      if (z !== exp_z[i-1]) begin
        errors++;
        $display("FAIL rise_z edge %0d: got %b expected %b", i, z, exp_z[i-1]);
      end
    end
  endtask

  task automatic test_short_pulse();
    logic [7:0] exp_settle;
    exp_settle = 8'b00011100;
    settle(1'b0);
    for (int i = 1; i <= 8; i++) begin
      step((i <= 3) ? 1'b1 : 1'b0);
      checks++;
      if (z !== 1'b0) begin
        errors++;
        $display("FAIL pulse_z step %0d: got %b expected 0", i, z);
      end
      checks++;
      if (settling !== exp_settle[i-1]) begin
        errors++;
        $display("FAIL pulse_settling step %0d: got %b expected %b", i, settling, exp_settle[i-1]);
      end
    end
  endtask

  task automatic test_bounce();
    logic [5:0] pat;
    pat = 6'b101101;  // bit i-1 = x on step i: 1,0,1,1,0,1
    settle(1'b0);
    for (int i = 1; i <= 12; i++) begin
      step((i <= 6) ? pat[i-1] : 1'b1);
      checks++;
      if (z !== (i >= 11)) begin
        errors++;
        $display("FAIL bounce_z step %0d: got %b expected %b", i, z, (i >= 11));
      end
    end
  endtask

  task automatic test_async_reset();
    settle(1'b0);
    for (int i = 0; i < 4; i++) step(1'b1);
    checks++;
    if (settling !== 1'b1) begin
      errors++;
      $display("FAIL areset_pre_settling: got %b expected 1", settling);
    end
    #10;
    rst = 1'b0;
    #1;
    checks++;
    if (settling !== 1'b0) begin
      errors++;
      $display("FAIL areset_settling: got %b expected 0", settling);
    end
    checks++;
    if (z !== 1'b0) begin
      errors++;
      $display("FAIL areset_z: got %b expected 0", z);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      step(1'b1);
      checks++;
      if (z !== (i == 6)) begin
        errors++;
        $display("FAIL areset_requal_z edge %0d: got %b expected %b", i, z, (i == 6));
      end
    end
  endtask

  task automatic test_lab_pattern();
    logic [15:0] pat;
    logic        z_prev;
    int          pulses;
    pat    = 16'b0100111101111100;
    pulses = 0;
    settle(1'b0);
    z_prev = 1'b0;
    for (int i = 1; i <= 18; i++) begin
      step((i <= 16) ? pat[16-i] : 1'b0);
      if (z === 1'b1 && z_prev === 1'b0) pulses++;
      z_prev = z;
      checks++;
      if (z !== (i >= 10)) begin
        errors++;
        $display("FAIL lab_z step %0d: got %b expected %b", i, z, (i >= 10));
      end
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL lab_edge_pulses: got %0d expected 1", pulses);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b0;
    x   = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_fall();
    test_clean_rise();
    test_short_pulse();
    test_bounce();
    test_async_reset();
    test_lab_pattern();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
